instr_issuer: RTL and testbench
===============================

Name: instr_issuer

Overview:
- Initiator side of the run/done handshake into the processor control unit.
- Fetches 9-bit instruction words (III XXX YYY) from a synchronous program memory and presents each one on ir.
- For MVI it also fetches the following immediate word and drives it on din.
- Pulses run, waits for done, then advances the program counter; halts at the end of the program.

Parameters:
- DATA_W, 9: instruction/data word width.
- ADDR_W, 5: program-memory address width.
- PROG_LEN, 16: number of memory words in the program. The issuer halts when pc reaches PROG_LEN.
- DONE_TIMEOUT, 15: maximum number of cycles to wait for done before flagging an error.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts execution from address 0 when idle or halted.
- mem_addr  out  ADDR_W  program-memory address.
- mem_rd  out  1  memory read strobe.
- mem_data  in  DATA_W  memory read data, valid exactly 1 cycle after mem_rd.
- ir  out  DATA_W  instruction to the control unit.
- din  out  DATA_W  immediate word for MVI; 0 otherwise.
- run  out  1  one-cycle start strobe to the control unit.
- done  in  1  completion strobe from the control unit.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  program finished.
- timeout_err  out  1  sticky; done did not arrive within DONE_TIMEOUT cycles.
- pc  out  ADDR_W  address of the current instruction.

Behaviour:
- Reset values (take effect on the clock edge while reset=1, from any state): state=IDLE, pc=0, ir=0, din=0, run=0, mem_rd=0, mem_addr=0, busy=0, halted=0, timeout_err=0.
- IDLE: waits for start; then goes to FETCH.
- FETCH: mem_addr=pc, mem_rd=1 for one cycle; then goes to WAIT_IR.
- WAIT_IR: latches mem_data into ir; then goes to DECODE.
- DECODE: if ir[8:6]==OP_MVI, goes to FETCH_IMM; otherwise din=0 and goes to ISSUE.
- FETCH_IMM: requires pc+1 < PROG_LEN, else sets halted and goes to HALT without issuing. Drives mem_addr=pc+1, mem_rd=1; then goes to WAIT_IMM.
- WAIT_IMM: latches mem_data into din; then goes to ISSUE.
- ISSUE: run=1 for exactly one cycle; clears the timeout counter; then goes to WAIT_DONE.
- WAIT_DONE: ir and din held stable.
  - On done: pc advances by 1, or by 2 for MVI; then goes to CHECK.
  - Counter reaches DONE_TIMEOUT without done: timeout_err=1, goes to HALT.
  - done in the same cycle the counter expires: done wins.
- CHECK: if the new pc >= PROG_LEN, halted=1 and goes to HALT; else goes to FETCH.
- Counting the ISSUE cycle as cycle 0, run asserts in cycle 0 and done is sampled in cycle 1 onward.
- HALT: outputs held; start clears halted and timeout_err, sets pc=0, goes to FETCH.
- start is ignored while busy.
- done outside WAIT_DONE is ignored.
- pc wraps modulo 2^ADDR_W in arithmetic; PROG_LEN <= 2^ADDR_W is required.
- Opcodes 1xx (unsupported) are still issued as-is; the issuer does not decode beyond MVI.
- Minimum per-instruction overhead: 5 cycles for non-MVI (FETCH, WAIT_IR, DECODE, ISSUE, CHECK) plus the control unit's latency; MVI adds 2 cycles.

Optional Feature:
- Macro: INSTR_ISSUER_STEP_EN.
- When defined:
  - Adds an input port step (1 bit).
  - Adds a state STEP_WAIT entered from CHECK when not halting.
  - STEP_WAIT proceeds to FETCH only on a step pulse; busy stays high.
  - The first instruction after start also waits for step.
- When undefined: no step port; CHECK goes directly to FETCH.

Decomposition:
- Shared package processor_pkg:
  - Opcode constants: OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011.
  - Field slices: opcode [8:6], rx [5:3], ry [2:0].
  - State enum for the issuer FSM.
- One sub-module, done_watchdog: cycle counter with clear and enable, producing the expire flag.

Test Plan:
- Program [MV R1,R0 = 9'b000001000], PROG_LEN=1, bench responder asserts done 2 cycles after run -> one run pulse with ir=9'b000001000 and din=0; pc=1; halted=1; busy=0.
- Program [MVI R0 = 9'b001000000, imm 9'd2], PROG_LEN=2 -> ir=9'b001000000 and din=2 stable from the run cycle until done; pc ends at 2; exactly one run pulse.
- Program [MVI R0 #2, MV R1,R0, ADD R1,R1, SUB R2,R0], PROG_LEN=5 -> run pulses with ir in order 001000000, 000001000, 010001001, 011010000; halted after the 4th done.
- Responder never asserts done -> timeout_err=1 exactly DONE_TIMEOUT cycles after run; state HALT; a following start clears the flag and restarts at pc=0.
- reset asserted during WAIT_DONE, and start pulsed while busy -> after reset all outputs return to reset values next edge; start while busy has no effect on pc or run count.
- With INSTR_ISSUER_STEP_EN defined -> no FETCH (mem_rd) until a step pulse; one instruction issued per step pulse.

Source files
------------

// File: rtl/processor_pkg.sv
// processor_pkg: opcode constants, instruction field helpers and issuer FSM state encoding
package processor_pkg;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT_IR, DECODE, FETCH_IMM, WAIT_IMM, ISSUE, WAIT_DONE, CHECK, HALT, STEP_WAIT
  } issuer_state_e;
  function automatic logic [2:0] opcode(input logic [8:0] w);
    return w[8:6];
  endfunction
  function automatic logic [2:0] rx(input logic [8:0] w);
    return w[5:3];
  endfunction
  function automatic logic [2:0] ry(input logic [8:0] w);
    return w[2:0];
  endfunction
endpackage

// File: rtl/done_watchdog.sv
// done_watchdog: counts cycles spent waiting for done and flags expiry on the last permitted cycle
module done_watchdog #(
  parameter int LIMIT = 14
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  assign expire = en && (cnt == CW'(LIMIT - 1));
  // count waiting cycles, freezing once the limit is hit
  always_ff @(posedge clock) begin
    if (reset || clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/instr_issuer.sv
// instr_issuer: fetches program words, drives run/done handshake; INSTR_ISSUER_STEP_EN adds single-step gating
module instr_issuer
  import processor_pkg::*;
#(
  parameter int DATA_W       = 9,
  parameter int ADDR_W       = 5,
  parameter int PROG_LEN     = 16,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef INSTR_ISSUER_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] pc
);
  localparam logic [ADDR_W:0] LEN = (ADDR_W + 1)'(PROG_LEN);
`ifdef INSTR_ISSUER_STEP_EN
  localparam issuer_state_e RESUME = STEP_WAIT;
`else
  localparam issuer_state_e RESUME = FETCH;
`endif
  issuer_state_e state;
  logic expire, is_mvi, imm_ok, at_end;
  logic [ADDR_W-1:0] pc_p1;
  assign pc_p1  = pc + ADDR_W'(1);
  assign is_mvi = opcode(ir) == OP_MVI;
  assign imm_ok = {1'b0, pc_p1} < LEN;
  assign at_end = {1'b0, pc} >= LEN;
  assign busy   = !(state inside {IDLE, HALT});
  // done is sampled in cycles 1..DONE_TIMEOUT-1 after run, so the flag lands DONE_TIMEOUT cycles after run
  done_watchdog #(.LIMIT(DONE_TIMEOUT - 1)) u_wd (
    .clock (clock),
    .reset (reset),
    .clr   (state == ISSUE),
    .en    (state == WAIT_DONE),
    .expire(expire)
  );
  // issuer FSM; strobes default low and are raised on the transition into the state that owns them
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      din         <= '0;
      run         <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      run    <= 1'b0;
      mem_rd <= 1'b0;
      case (state)
        IDLE, HALT: if (start) begin
          halted      <= 1'b0;
          timeout_err <= 1'b0;
          pc          <= '0;
          mem_addr    <= '0;
          mem_rd      <= RESUME == FETCH;
          state       <= RESUME;
        end
`ifdef INSTR_ISSUER_STEP_EN
        STEP_WAIT: if (step) begin
          mem_rd <= 1'b1;
          state  <= FETCH;
        end
`endif
        FETCH: state <= WAIT_IR;
        WAIT_IR: begin
          ir    <= mem_data;
          state <= DECODE;
        end
        DECODE: if (is_mvi) begin
          mem_rd   <= imm_ok;
          mem_addr <= pc_p1;
          state    <= FETCH_IMM;
        end else begin
          din   <= '0;
          run   <= 1'b1;
          state <= ISSUE;
        end
        FETCH_IMM: if (!imm_ok) begin
          halted <= 1'b1;
          state  <= HALT;
        end else state <= WAIT_IMM;
        WAIT_IMM: begin
          din   <= mem_data;
          run   <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: if (done) begin
          pc    <= pc + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
          state <= CHECK;
        end else if (expire) begin
          timeout_err <= 1'b1;
          state       <= HALT;
        end
        CHECK: if (at_end) begin
          halted <= 1'b1;
          state  <= HALT;
        end else begin
          mem_addr <= pc;
          mem_rd   <= RESUME == FETCH;
          state    <= RESUME;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: directed checks on three issuers (PROG_LEN 1, 2, 5) sharing start/reset
module tb_instr_issuer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, step_hold = 1'b1;
  logic [2:0] resp_en = '1;
  logic [2:0] mem_rd, run, done, busy, halted, terr, terr_prev = '0;
  logic [2:0][4:0] mem_addr, pc;
  logic [2:0][8:0] mem_data, ir, din;
  logic [2:0][1:0] sh = '0;
  logic [8:0] mem [3][32];
  logic [8:0] ir_log [3][64];
  logic [8:0] din_log [3][64];
  logic [8:0] ir_d [3];
  logic [8:0] din_d [3];
  int nrun [3], nrd [3], run_cyc [3], terr_cyc [3];
  int cyc = 0, checks = 0, errors = 0, b0, b1, b2, brd, n;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : u
    instr_issuer #(.DATA_W(9), .ADDR_W(5), .PROG_LEN(g == 0 ? 1 : g == 1 ? 2 : 5), .DONE_TIMEOUT(15)) dut (
      .clock(clock), .reset(reset), .start(start),
`ifdef INSTR_ISSUER_STEP_EN
      .step(step_hold),
`endif
      .mem_addr(mem_addr[g]), .mem_rd(mem_rd[g]), .mem_data(mem_data[g]),
      .ir(ir[g]), .din(din[g]), .run(run[g]), .done(done[g]),
      .busy(busy[g]), .halted(halted[g]), .timeout_err(terr[g]), .pc(pc[g])
    );
  end

  always @(posedge clock)
    for (int i = 0; i < 3; i++) begin
      if (mem_rd[i]) mem_data[i] <= mem[i][mem_addr[i]];
      sh[i] <= {sh[i][0], run[i]};
    end

  always_comb
    for (int i = 0; i < 3; i++) done[i] = resp_en[i] & sh[i][1];

  always @(negedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (run[i]) begin
        ir_log[i][nrun[i] % 64] <= ir[i];
        din_log[i][nrun[i] % 64] <= din[i];
        run_cyc[i] <= cyc;
        nrun[i] <= nrun[i] + 1;
      end
      if (done[i]) begin
        ir_d[i] <= ir[i];
        din_d[i] <= din[i];
      end
      if (mem_rd[i]) nrd[i] <= nrd[i] + 1;
      if (terr[i] && !terr_prev[i]) terr_cyc[i] <= cyc;
    end
    terr_prev <= terr;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input logic [2:0] m, input string tag);
    int k = 0;
    while ((busy & m) != 0 && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 32'((busy & m) == 0), 1);
  endtask

  task automatic check_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_pc", pc[i], 0);
      chk("rst_ir", ir[i], 0);
      chk("rst_din", din[i], 0);
      chk("rst_addr", mem_addr[i], 0);
      chk("rst_ctl", {run[i], mem_rd[i], busy[i], halted[i], terr[i]}, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 32; a++) mem[i][a] = '0;
    mem[0][0] = 9'b000001000;
    mem[1][0] = 9'b001000000;
    mem[1][1] = 9'd2;
    mem[2][0] = 9'b001000000;
    mem[2][1] = 9'd2;
    mem[2][2] = 9'b000001000;
    mem[2][3] = 9'b010001001;
    mem[2][4] = 9'b011010000;
    tick();
    tick();
    check_reset();
    reset = 1'b0;
    tick();
    b0 = nrun[0]; b1 = nrun[1]; b2 = nrun[2];
    pulse_start();
    wait_idle(3'b111, "prog_idle");
    chk("mv_runs", nrun[0] - b0, 1);
    chk("mv_ir", ir_log[0][b0], 9'b000001000);
    chk("mv_din", din_log[0][b0], 0);
    chk("mv_pc", pc[0], 1);
    chk("mv_halted", halted[0], 1);
    chk("mvi_runs", nrun[1] - b1, 1);
    chk("mvi_ir", ir_log[1][b1], 9'b001000000);
    chk("mvi_din", din_log[1][b1], 2);
    chk("mvi_ir_at_done", ir_d[1], 9'b001000000);
    chk("mvi_din_at_done", din_d[1], 2);
    chk("mvi_pc", pc[1], 2);
    chk("mvi_halted", halted[1], 1);
    chk("seq_runs", nrun[2] - b2, 4);
    chk("seq_ir0", ir_log[2][b2], 9'b001000000);
    chk("seq_din0", din_log[2][b2], 2);
    chk("seq_ir1", ir_log[2][b2 + 1], 9'b000001000);
    chk("seq_ir2", ir_log[2][b2 + 2], 9'b010001001);
    chk("seq_ir3", ir_log[2][b2 + 3], 9'b011010000);
    chk("seq_din3", din_log[2][b2 + 3], 0);
    chk("seq_pc", pc[2], 5);
    chk("seq_halted", halted[2], 1);
    resp_en[0] = 1'b0;
    pulse_start();
    wait_idle(3'b111, "timeout_idle");
    chk("to_err", terr[0], 1);
    chk("to_halted_flag", halted[0], 0);
    chk("to_delay", terr_cyc[0] - run_cyc[0], 15);
    chk("to_pc", pc[0], 0);
    resp_en[0] = 1'b1;
    pulse_start();
    chk("to_cleared", terr[0], 0);
`ifdef INSTR_ISSUER_STEP_EN
    tick();
`endif
    chk("restart_fetch", {mem_rd[0], mem_addr[0]}, {1'b1, 5'd0});
    wait_idle(3'b111, "restart_idle");
    chk("restart_pc", pc[0], 1);
    chk("restart_halted", halted[0], 1);
    b2 = nrun[2];
    pulse_start();
    repeat (3) tick();
    pulse_start();
    chk("busy_start_pc", pc[2], 0);
    wait_idle(3'b111, "busy_idle");
    chk("busy_start_runs", nrun[2] - b2, 4);
    chk("busy_start_pc_end", pc[2], 5);
    resp_en[2] = 1'b0;
    b2 = nrun[2];
    pulse_start();
    n = 0;
    while (nrun[2] == b2 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_run", 32'(nrun[2] != b2), 1);
    tick();
    chk("in_wait_done", busy[2], 1);
    reset = 1'b1;
    tick();
    check_reset();
    reset = 1'b0;
    resp_en = '1;
    tick();
`ifdef INSTR_ISSUER_STEP_EN
    step_hold = 1'b0;
    brd = nrd[0]; b0 = nrun[0]; b2 = nrun[2];
    pulse_start();
    repeat (8) tick();
    chk("step_no_fetch", nrd[0] - brd, 0);
    chk("step_busy", busy[0], 1);
    step_hold = 1'b1;
    tick();
    step_hold = 1'b0;
    repeat (12) tick();
    chk("step1_runs0", nrun[0] - b0, 1);
    chk("step1_runs2", nrun[2] - b2, 1);
    step_hold = 1'b1;
    tick();
    step_hold = 1'b0;
    repeat (12) tick();
    chk("step2_runs2", nrun[2] - b2, 2);
    chk("step_halted0", halted[0], 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
